syscall_unit: RTL and testbench
===============================

SYSCALL_UNIT -- requirements
Module: syscall_unit

Interface
REQ-001 Parameter: MAX_LEN, 1024, max characters emitted per print_string (truncation limit).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 syscall  input  1  one-cycle pulse: syscall instruction in execute.
REQ-005 sys_call_reg  input  32  $v0 value from register file (service code).
REQ-006 std_out_address  input  32  $a0 value from register file (argument / string address).
REQ-007 mem_req  output  1  data-memory read request.
REQ-008 mem_addr  output  32  word-aligned read address (bits [1:0] = 0).
REQ-009 mem_ack  input  1  read data valid on mem_rdata this cycle.
REQ-010 mem_rdata  input  32  read word, big-endian.
REQ-011 out_valid  output  1  character available on out_char.
REQ-012 out_char  output  8  ASCII character to stdout.
REQ-013 out_ready  input  1  stdout sink accepts character.
REQ-014 stall  output  1  freeze CPU pipeline.
REQ-015 halt  output  1  program exited; sticky.
REQ-016 bad_code  output  1  one-cycle pulse: unsupported service code.

Function
REQ-017 States: IDLE, FETCH, EMIT, HEX, HALT; reset state IDLE.
REQ-018 In IDLE, the syscall pulse is sampled on the rising edge; $v0 and $a0 are captured into internal code/ptr registers on that same edge.
REQ-019 stall is combinational: high when syscall=1 in IDLE with code 1, 4 or 10, and high in FETCH/EMIT/HEX/HALT; low otherwise.
REQ-020 Code 4 (print_string): IDLE->FETCH; set ptr=$a0 and count=0.
REQ-021 FETCH: mem_req=1, mem_addr={ptr[31:2],2'b00}, both held stable until mem_ack.
REQ-022 On mem_ack, select the byte for ptr[1:0]: 0->[31:24], 1->[23:16], 2->[15:8], 3->[7:0].
REQ-023 A selected byte of 0x00 ends the service (->IDLE, nothing emitted); otherwise latch it into out_char and go to EMIT.
REQ-024 EMIT: out_valid=1 with out_char stable until out_ready=1; on handshake ptr+=1 (wraps mod 2^32) and count+=1.
REQ-025 After a handshake: count==MAX_LEN -> IDLE; otherwise -> FETCH; one fetch per character, no word caching.
REQ-026 Code 1 (print_int): IDLE->HEX; emit $a0 as exactly 8 lowercase hex ASCII digits, MSB nibble first, with no prefix, each digit using the out_valid/out_ready handshake; after the 8th handshake go to IDLE.
REQ-027 Code 10 (exit): IDLE->HALT; halt=1 from the next cycle and held with stall=1 until rst.
REQ-028 Any other code: bad_code=1 for the cycle after sampling, no stall, remain IDLE.
REQ-029 syscall pulses outside IDLE are ignored; mem_ack outside FETCH is ignored.
REQ-030 out_valid only in EMIT/HEX; mem_req only in FETCH; at most one character accepted per cycle.
REQ-031 Service completes with stall deasserting in the cycle the FSM is in IDLE.

Reset
REQ-032 rst has priority over all inputs; on the reset edge the FSM goes to IDLE.
REQ-033 Reset values: mem_req=0, mem_addr=0, out_valid=0, out_char=0, stall=0, halt=0, bad_code=0, ptr=0, count=0.
REQ-034 rst during FETCH/EMIT/HEX/HALT aborts the service: a pending character is discarded and no further handshake occurs.

Verification
REQ-035 Memory word 0x48690000 at 0x100, $v0=4, $a0=0x100, out_ready=1 -> out_char 'H'(0x48), 'i'(0x69); stall then drops; 2 mem_req transactions + 1 NUL fetch.
REQ-036 $v0=4, $a0=0x103 (unaligned), word@0x100=0x00000041, word@0x104=0x00xxxxxx -> single 'A'; mem_addr 0x100 then 0x104.
REQ-037 $v0=1, $a0=0xDEADBEEF, out_ready toggling every other cycle -> "deadbeef" in order; out_char stable while out_valid && !out_ready.
REQ-038 $v0=10 -> halt=1 and stall=1 from next cycle; later syscall pulses are ignored; rst -> halt=0, IDLE.
REQ-039 $v0=7 -> bad_code pulses for 1 cycle, stall stays 0; string without NUL and MAX_LEN=4 -> exactly 4 characters, then IDLE.
REQ-040 rst asserted mid-EMIT with out_ready=0 -> out_valid=0 next cycle, no character accepted; a new $v0=4 service then runs normally.

Source files
------------

// File: rtl/syscall_unit.sv
// Syscall service unit: print_string (code 4), print_int as 8 hex digits (code 1), exit (code 10).
// Holds the CPU pipeline via stall while a service is in progress.
module syscall_unit #(
   parameter int MAX_LEN = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        syscall,
   input  logic [31:0] sys_call_reg,
   input  logic [31:0] std_out_address,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   output logic [7:0]  out_char,
   input  logic        out_ready,
   output logic        stall,
   output logic        halt,
   output logic        bad_code
);

   // count doubles as the hex digit index, so it needs at least 3 bits
   localparam int CW_RAW = $clog2(MAX_LEN + 1);
   localparam int CW     = (CW_RAW < 3) ? 3 : CW_RAW;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EMIT,
      HEX,
      HALT
   } state_t;

   state_t          r_state;
   state_t          w_state_nx;
   logic [31:0]     r_ptr;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_inc;
   logic [7:0]      r_char;
   logic            r_bad;
   logic            w_code_ok;
   logic [7:0]      w_byte;
   logic [31:0]     w_shift;
   logic [3:0]      w_nib;
   logic [7:0]      w_hex;

   assign w_code_ok   = (sys_call_reg == 32'd1) || (sys_call_reg == 32'd4) ||
                        (sys_call_reg == 32'd10);
   assign w_count_inc = r_count + 1'b1;

   always_comb begin
      case (r_ptr[1:0])
         2'd0:    w_byte = mem_rdata[31:24];
         2'd1:    w_byte = mem_rdata[23:16];
         2'd2:    w_byte = mem_rdata[15:8];
         default: w_byte = mem_rdata[7:0];
      endcase
   end

   // Digit r_count of the captured value, MSB nibble first
   assign w_shift = r_ptr << {r_count[2:0], 2'b00};
   assign w_nib   = w_shift[31:28];
   assign w_hex   = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h57 + {4'h0, w_nib});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      stall      = 1'b0;
      mem_req    = 1'b0;
      mem_addr   = '0;
      out_valid  = 1'b0;
      out_char   = r_char;
      halt       = 1'b0;
      case (r_state)
         IDLE: begin
            if (syscall) begin
               stall = w_code_ok;
               if (sys_call_reg == 32'd4) begin
                  w_state_nx = FETCH;
               end else if (sys_call_reg == 32'd1) begin
                  w_state_nx = HEX;
               end else if (sys_call_reg == 32'd10) begin
                  w_state_nx = HALT;
               end
            end
         end
         FETCH: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = {r_ptr[31:2], 2'b00};
            if (mem_ack) begin
               w_state_nx = (w_byte == 8'h00) ? IDLE : EMIT;
            end
         end
         EMIT: begin
            stall     = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nx = (w_count_inc == CW'(MAX_LEN)) ? IDLE : FETCH;
            end
         end
         HEX: begin
            stall     = 1'b1;
            out_valid = 1'b1;
            out_char  = w_hex;
            if (out_ready && (r_count == CW'(7))) begin
               w_state_nx = IDLE;
            end
         end
         HALT: begin
            stall = 1'b1;
            halt  = 1'b1;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   assign bad_code = r_bad;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr   <= '0;
         r_count <= '0;
         r_char  <= '0;
         r_bad   <= 1'b0;
      end else begin
         r_bad <= 1'b0;
         case (r_state)
            IDLE: begin
               if (syscall) begin
                  r_ptr   <= std_out_address;
                  r_count <= '0;
                  r_bad   <= !w_code_ok;
               end
            end
            FETCH: begin
               if (mem_ack && (w_byte != 8'h00)) begin
                  r_char <= w_byte;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  r_ptr   <= r_ptr + 32'd1;
                  r_count <= w_count_inc;
               end
            end
            HEX: begin
               if (out_ready) begin
                  r_count <= w_count_inc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit (MAX_LEN=4): strings, hex print, exit, bad code, reset abort.
module tb_syscall_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        syscall = 1'b0;
   logic [31:0] sys_call_reg = '0;
   logic [31:0] std_out_address = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        out_valid;
   logic [7:0]  out_char;
   logic        out_ready = 1'b0;
   logic        stall;
   logic        halt;
   logic        bad_code;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] mem [logic [31:0]];
   logic [7:0]  q_chars [$];
   logic [31:0] q_addr [$];
   logic        toggle_rdy = 1'b0;
   logic        hold_prev  = 1'b0;
   logic [7:0]  prev_char  = '0;
   int          unstable   = 0;

   syscall_unit #(.MAX_LEN(4)) dut (
      .clk(clk), .rst(rst), .syscall(syscall), .sys_call_reg(sys_call_reg),
      .std_out_address(std_out_address), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
      .out_char(out_char), .out_ready(out_ready), .stall(stall), .halt(halt),
      .bad_code(bad_code)
   );

   always #5 clk = ~clk;

   // Memory responder and stdout sink, both acting half a cycle ahead of the consuming edge
   always @(negedge clk) begin
      if (toggle_rdy) out_ready = ~out_ready;
      if (mem_req) begin
         mem_ack   = 1'b1;
         mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
         q_addr.push_back(mem_addr);
      end else begin
         mem_ack   = 1'b0;
         mem_rdata = '0;
      end
      if (out_valid && out_ready && !rst) q_chars.push_back(out_char);
      if (hold_prev && out_valid && (out_char !== prev_char)) unstable++;
      hold_prev = out_valid && !out_ready && !rst;
      prev_char = out_char;
   end

   task automatic do_syscall(input logic [31:0] code, input logic [31:0] a0,
                             output logic stall_at_pulse);
      @(posedge clk); #1;
      syscall = 1'b1; sys_call_reg = code; std_out_address = a0;
      #1 stall_at_pulse = stall;
      @(posedge clk); #1;
      syscall = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      for (k = 0; k < 200; k++) begin
         if (!stall) break;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (k == 200) begin
         n_err++;
         $display("FAIL %s_timeout: stall still %b, required 0 within 200 cycles", name, stall);
      end
   endtask

   task automatic check_chars(input string name, input logic [7:0] exp [$]);
      n_cmp++;
      if (q_chars.size() !== exp.size()) begin
         n_err++;
         $display("FAIL %s_count: got %0d chars, required %0d", name, q_chars.size(), exp.size());
      end else begin
         for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (q_chars[i] !== exp[i]) begin
               n_err++;
               $display("FAIL %s_char%0d: got %h, required %h", name, i, q_chars[i], exp[i]);
            end
         end
      end
   endtask

   task automatic check_addrs(input string name, input logic [31:0] exp [$]);
      n_cmp++;
      if (q_addr.size() !== exp.size()) begin
         n_err++;
         $display("FAIL %s_fetches: got %0d, required %0d", name, q_addr.size(), exp.size());
      end else begin
         for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (q_addr[i] !== exp[i]) begin
               n_err++;
               $display("FAIL %s_addr%0d: got %h, required %h", name, i, q_addr[i], exp[i]);
            end
         end
      end
   endtask

   task automatic clear_logs();
      q_chars.delete(); q_addr.delete(); unstable = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp += 7;
      if (mem_req   !== 1'b0)  begin n_err++; $display("FAIL rst_mem_req: got %b, required 0", mem_req); end
      if (mem_addr  !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h, required 0", mem_addr); end
      if (out_valid !== 1'b0)  begin n_err++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
      if (out_char  !== 8'h0)  begin n_err++; $display("FAIL rst_out_char: got %h, required 0", out_char); end
      if (stall     !== 1'b0)  begin n_err++; $display("FAIL rst_stall: got %b, required 0", stall); end
      if (halt      !== 1'b0)  begin n_err++; $display("FAIL rst_halt: got %b, required 0", halt); end
      if (bad_code  !== 1'b0)  begin n_err++; $display("FAIL rst_bad_code: got %b, required 0", bad_code); end
      rst = 1'b0;
   endtask

   task automatic test_print_string();
      logic s;
      mem.delete(); mem[32'h100] = 32'h48690000;
      out_ready = 1'b1; clear_logs();
      do_syscall(32'd4, 32'h100, s);
      n_cmp++;
      if (s !== 1'b1) begin n_err++; $display("FAIL str_stall_pulse: got %b, required 1", s); end
      wait_idle("str");
      check_chars("str", '{8'h48, 8'h69});
      check_addrs("str", '{32'h100, 32'h100, 32'h100});
   endtask

   task automatic test_unaligned();
      logic s;
      mem.delete(); mem[32'h100] = 32'h00000041; mem[32'h104] = 32'h00FFFFFF;
      out_ready = 1'b1; clear_logs();
      do_syscall(32'd4, 32'h103, s);
      wait_idle("unal");
      check_chars("unal", '{8'h41});
      check_addrs("unal", '{32'h100, 32'h104});
   endtask

   task automatic test_print_int();
      logic s;
      out_ready = 1'b0; clear_logs();
      toggle_rdy = 1'b1;
      do_syscall(32'd1, 32'hDEADBEEF, s);
      wait_idle("hex");
      toggle_rdy = 1'b0;
      out_ready = 1'b1;
      check_chars("hex", '{8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66});
      n_cmp++;
      if (unstable !== 0) begin n_err++; $display("FAIL hex_stable: got %0d changes while stalled, required 0", unstable); end
      n_cmp++;
      if (q_addr.size() !== 0) begin n_err++; $display("FAIL hex_no_fetch: got %0d fetches, required 0", q_addr.size()); end
   endtask

   task automatic test_max_len();
      logic s;
      mem.delete(); mem[32'h200] = 32'h41424344; mem[32'h204] = 32'h45464748;
      out_ready = 1'b1; clear_logs();
      do_syscall(32'd4, 32'h200, s);
      wait_idle("maxlen");
      check_chars("maxlen", '{8'h41, 8'h42, 8'h43, 8'h44});
      check_addrs("maxlen", '{32'h200, 32'h200, 32'h200, 32'h200});
   endtask

   task automatic test_bad_code();
      logic s;
      clear_logs();
      do_syscall(32'd7, 32'h0, s);
      n_cmp += 4;
      if (s        !== 1'b0) begin n_err++; $display("FAIL bad_stall_pulse: got %b, required 0", s); end
      if (bad_code !== 1'b1) begin n_err++; $display("FAIL bad_pulse: got %b, required 1", bad_code); end
      if (stall    !== 1'b0) begin n_err++; $display("FAIL bad_stall: got %b, required 0", stall); end
      @(posedge clk); #1;
      if (bad_code !== 1'b0) begin n_err++; $display("FAIL bad_pulse_end: got %b, required 0", bad_code); end
   endtask

   task automatic test_reset_mid_emit();
      logic s;
      int k;
      mem.delete(); mem[32'h100] = 32'h48690000;
      out_ready = 1'b0; clear_logs();
      do_syscall(32'd4, 32'h100, s);
      for (k = 0; k < 20 && !out_valid; k++) begin @(posedge clk); #1; end
      n_cmp++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL abort_reach_emit: out_valid %b, required 1", out_valid); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp += 3;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_out_valid: got %b, required 0", out_valid); end
      if (stall     !== 1'b0) begin n_err++; $display("FAIL abort_stall: got %b, required 0", stall); end
      if (q_chars.size() !== 0) begin n_err++; $display("FAIL abort_chars: got %0d, required 0", q_chars.size()); end
      out_ready = 1'b1; clear_logs();
      do_syscall(32'd4, 32'h100, s);
      wait_idle("rerun");
      check_chars("rerun", '{8'h48, 8'h69});
   endtask

   task automatic test_halt();
      logic s;
      clear_logs();
      do_syscall(32'd10, 32'h0, s);
      n_cmp += 3;
      if (s     !== 1'b1) begin n_err++; $display("FAIL halt_stall_pulse: got %b, required 1", s); end
      if (halt  !== 1'b1) begin n_err++; $display("FAIL halt_set: got %b, required 1", halt); end
      if (stall !== 1'b1) begin n_err++; $display("FAIL halt_stall: got %b, required 1", stall); end
      do_syscall(32'd4, 32'h100, s);
      repeat (4) @(posedge clk);
      #1;
      n_cmp += 3;
      if (halt  !== 1'b1) begin n_err++; $display("FAIL halt_sticky: got %b, required 1", halt); end
      if (q_addr.size() !== 0) begin n_err++; $display("FAIL halt_ignore: got %0d fetches, required 0", q_addr.size()); end
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL halt_no_out: got %b, required 0", out_valid); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp += 2;
      if (halt  !== 1'b0) begin n_err++; $display("FAIL halt_clear: got %b, required 0", halt); end
      if (stall !== 1'b0) begin n_err++; $display("FAIL halt_clear_stall: got %b, required 0", stall); end
   endtask

   initial begin
      test_reset();
      test_print_string();
      test_unaligned();
      test_print_int();
      test_max_len();
      test_bad_code();
      test_reset_mid_emit();
      test_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
